// File: rtl/pipelined_adder_pkg.sv
// Shared constants for the pipelined add/subtract unit: default geometry,
// op-select encodings and the configuration legality rule.
package pipelined_adder_pkg;

   localparam int unsigned DEF_WIDTH     = 32;
   localparam int unsigned DEF_STAGES    = 4;
   localparam int unsigned DEF_TAG_WIDTH = 6;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Depth must be 1..width and split the word into equal chunks.
   function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
      if (stages < 1 || stages > width) begin
         return 1'b0;
      end
      return (width % stages) == 0;
   endfunction

endpackage

// File: rtl/FA_X1.sv
// Behavioural view of the library full-adder cell, used by the ripple
// chains so that simulation and lint see the same netlist structure.
module FA_X1 (
   input  logic A,
   input  logic B,
   input  logic CI,
   output logic S,
   output logic CO
);

   assign S  = A ^ B ^ CI;
   assign CO = (A & B) | (CI & (A ^ B));

endmodule

// File: rtl/adder_chunk.sv
// Combinational W-bit ripple-carry chain of FA_X1 cells; also exposes the
// carry into the top bit so the caller can derive signed overflow.
module adder_chunk #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         c_msb
);

   // Each cell keeps its own carry nets so the chain stays a clean feed-forward path.
   for (genvar i = 0; i < W; i++) begin : g_fa
      logic w_ci;
      logic w_co;

      if (i == 0) begin : g_lsb
         assign w_ci = cin;
      end else begin : g_rip
         assign w_ci = g_fa[i-1].w_co;
      end

      FA_X1 u_fa (
         .A  (a[i]),
         .B  (b[i]),
         .CI (w_ci),
         .S  (sum[i]),
         .CO (w_co)
      );
   end

   assign cout  = g_fa[W-1].w_co;
   assign c_msb = g_fa[W-1].w_ci;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: one CHUNK-bit ripple slice per stage, carry registered
// between stages, valid/ready handshake with bubble collapse and a squash input.
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned STAGES    = DEF_STAGES,
   parameter int unsigned TAG_WIDTH = DEF_TAG_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_sub,
   input  logic [TAG_WIDTH-1:0] in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_sum,
   output logic                 out_cout,
   output logic                 out_ovf,
   output logic [TAG_WIDTH-1:0] out_tag
);

   localparam int unsigned CHUNK = WIDTH / STAGES;

   if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
      $error("pipelined_adder: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
   end

   // Stage registers; stage i has finished sum bits [(i+1)*CHUNK-1:0].
   logic [STAGES-1:0]    r_valid;
   logic [TAG_WIDTH-1:0] r_tag [STAGES];
   logic                 r_cy  [STAGES];
   logic [WIDTH-1:0]     r_sum [STAGES];
   logic [WIDTH-1:0]     r_a   [STAGES];
   logic [WIDTH-1:0]     r_b   [STAGES];
   logic                 r_ovf;

   logic [STAGES-1:0]    w_load;
   logic [STAGES-1:0]    w_src_v;
   logic [WIDTH-1:0]     w_src_a   [STAGES];
   logic [WIDTH-1:0]     w_src_b   [STAGES];
   logic [TAG_WIDTH-1:0] w_src_tag [STAGES];
   logic [WIDTH-1:0]     w_sum_nx  [STAGES];
   logic                 w_cy_nx   [STAGES];
   logic                 w_ovf_nx  [STAGES];
   logic [WIDTH-1:0]     w_b_eff;
   logic                 w_accept;

   assign w_b_eff  = (in_sub == OP_ADD) ? in_b : ~in_b;
   assign in_ready = ~flush & w_load[0];
   assign w_accept = in_valid & in_ready;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      logic [CHUNK-1:0] w_cs;
      logic             w_cin;
      logic             w_co;
      logic             w_cm;

      // A stage can take new data if any stage at or after it is empty, or the head leaves.
      assign w_load[i] = out_ready | ~(&r_valid[STAGES-1:i]);

      if (i == 0) begin : g_first
         assign w_src_v[i]   = w_accept;
         assign w_src_a[i]   = in_a;
         assign w_src_b[i]   = w_b_eff;
         assign w_src_tag[i] = in_tag;
         assign w_cin        = (in_sub == OP_SUB);
         assign w_sum_nx[i]  = WIDTH'(w_cs);
      end else begin : g_next
         localparam logic [WIDTH-1:0] L_MASK = WIDTH'({CHUNK{1'b1}}) << (i * CHUNK);

         assign w_src_v[i]   = r_valid[i-1];
         assign w_src_a[i]   = r_a[i-1];
         assign w_src_b[i]   = r_b[i-1];
         assign w_src_tag[i] = r_tag[i-1];
         assign w_cin        = r_cy[i-1];
         assign w_sum_nx[i]  = (r_sum[i-1] & ~L_MASK) | (WIDTH'(w_cs) << (i * CHUNK));
      end

      adder_chunk #(
         .W (CHUNK)
      ) u_chunk (
         .a     (w_src_a[i][i*CHUNK +: CHUNK]),
         .b     (w_src_b[i][i*CHUNK +: CHUNK]),
         .cin   (w_cin),
         .sum   (w_cs),
         .cout  (w_co),
         .c_msb (w_cm)
      );

      assign w_cy_nx[i]  = w_co;
      assign w_ovf_nx[i] = w_co ^ w_cm;
   end

   // Pipeline advance; data only moves with a valid op so bubbles keep stale payloads.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         r_ovf   <= 1'b0;
         for (int i = 0; i < int'(STAGES); i++) begin
            r_tag[i] <= '0;
            r_cy[i]  <= 1'b0;
            r_sum[i] <= '0;
            r_a[i]   <= '0;
            r_b[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < int'(STAGES); i++) begin
            if (flush) begin
               r_valid[i] <= 1'b0;
            end else if (w_load[i]) begin
               r_valid[i] <= w_src_v[i];
            end
            if (w_load[i] && w_src_v[i]) begin
               r_tag[i] <= w_src_tag[i];
               r_cy[i]  <= w_cy_nx[i];
               r_sum[i] <= w_sum_nx[i];
               r_a[i]   <= w_src_a[i];
               r_b[i]   <= w_src_b[i];
            end
         end
         if (w_load[STAGES-1] && w_src_v[STAGES-1]) begin
            r_ovf <= w_ovf_nx[STAGES-1];
         end
      end
   end

   assign out_valid = r_valid[STAGES-1];
   assign out_sum   = r_sum[STAGES-1];
   assign out_cout  = r_cy[STAGES-1];
   assign out_ovf   = r_ovf;
   assign out_tag   = r_tag[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (32-bit/4-stage main instance plus an
// 8-bit single-stage instance) against an arithmetic reference model.
module tb_pipelined_adder;

   localparam int unsigned W  = 32;
   localparam int unsigned S  = 4;
   localparam int unsigned TW = 6;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_ready, in_sub;
   logic [W-1:0]  in_a, in_b;
   logic [TW-1:0] in_tag;
   logic          out_valid, out_ready, out_cout, out_ovf;
   logic [W-1:0]  out_sum;
   logic [TW-1:0] out_tag;

   logic          d1_flush, d1_in_valid, d1_in_ready, d1_in_sub;
   logic [7:0]    d1_in_a, d1_in_b, d1_out_sum;
   logic [TW-1:0] d1_in_tag, d1_out_tag;
   logic          d1_out_valid, d1_out_ready, d1_out_cout, d1_out_ovf;

   always #5 clk = ~clk;

   pipelined_adder #(.WIDTH(W), .STAGES(S), .TAG_WIDTH(TW)) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_sub(in_sub), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_cout(out_cout), .out_ovf(out_ovf), .out_tag(out_tag)
   );

   pipelined_adder #(.WIDTH(8), .STAGES(1), .TAG_WIDTH(TW)) u_dut1 (
      .clk(clk), .rst(rst), .flush(d1_flush),
      .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_a(d1_in_a), .in_b(d1_in_b),
      .in_sub(d1_in_sub), .in_tag(d1_in_tag),
      .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_sum(d1_out_sum),
      .out_cout(d1_out_cout), .out_ovf(d1_out_ovf), .out_tag(d1_out_tag)
   );

   typedef struct {
      logic [W-1:0]  sum;
      logic          cout;
      logic          ovf;
      logic [TW-1:0] tag;
      int unsigned   cyc;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   int          acc_cnt = 0;
   bit          chk_lat = 1'b0;

   logic          p_hold = 1'b0;
   logic [W-1:0]  p_sum;
   logic          p_cout, p_ovf;
   logic [TW-1:0] p_tag;

   logic [W-1:0]  dir_a [5] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0};
   logic [W-1:0]  dir_b [5] = '{32'd1, 32'd7, 32'd1, 32'd1, 32'd0};
   logic          dir_s [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   logic [TW-1:0] dir_t [5] = '{6'd3, 6'd4, 6'd5, 6'd6, 6'd7};

   // Reference: plain integer arithmetic on the operand values.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic s, input logic [TW-1:0] t);
      exp_t       e;
      longint     sa, sb, sr, maxv, minv;
      logic [W:0] f;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      maxv = (longint'(1) <<< (W - 1)) - 1;
      minv = -(longint'(1) <<< (W - 1));
      sr   = s ? (sa - sb) : (sa + sb);
      e.ovf = (sr > maxv) || (sr < minv);
      if (s) begin
         e.sum  = a - b;
         e.cout = (a >= b);
      end else begin
         f      = {1'b0, a} + {1'b0, b};
         e.sum  = f[W-1:0];
         e.cout = f[W];
      end
      e.tag = t;
      e.cyc = 0;
      return e;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: hold stability, pop/compare on handshake, push on accept.
   always @(negedge clk) begin
      exp_t e;
      if (p_hold) begin
         checks++;
         if (!(out_valid === 1'b1 && out_sum === p_sum && out_tag === p_tag &&
               out_cout === p_cout && out_ovf === p_ovf)) begin
            errors++;
            $display("FAIL hold: valid=%b sum=%h tag=%0d, expected valid=1 sum=%h tag=%0d",
                     out_valid, out_sum, out_tag, p_sum, p_tag);
         end
      end
      if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected: result sum=%h tag=%0d with nothing outstanding", out_sum, out_tag);
         end else begin
            e = q.pop_front();
            if (out_sum !== e.sum || out_cout !== e.cout || out_ovf !== e.ovf || out_tag !== e.tag) begin
               errors++;
               $display("FAIL result: got sum=%h cout=%b ovf=%b tag=%0d, expected sum=%h cout=%b ovf=%b tag=%0d",
                        out_sum, out_cout, out_ovf, out_tag, e.sum, e.cout, e.ovf, e.tag);
            end
            if (chk_lat) begin
               checks++;
               if (cyc - e.cyc != S) begin
                  errors++;
                  $display("FAIL latency: got %0d cycles, expected %0d", cyc - e.cyc, S);
               end
            end
         end
      end
      if (!rst && in_valid === 1'b1 && in_ready === 1'b1) begin
         e     = model(in_a, in_b, in_sub, in_tag);
         e.cyc = cyc;
         q.push_back(e);
         acc_cnt++;
      end
      if (rst || flush) q.delete();
      p_hold = (out_valid === 1'b1) && (out_ready === 1'b0) && !rst && !flush;
      p_sum  = out_sum;
      p_cout = out_cout;
      p_ovf  = out_ovf;
      p_tag  = out_tag;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [TW-1:0] t);
      in_valid = v;
      in_a     = a;
      in_b     = b;
      in_sub   = s;
      in_tag   = t;
   endtask

   task automatic drive_rand(input logic v);
      logic [W-1:0] a, b;
      a = (($urandom % 4) == 0) ? W'(32'h8000_0000 - ($urandom % 2)) : W'($urandom);
      b = (($urandom % 4) == 0) ? W'($urandom % 3) : W'($urandom);
      drive(v, a, b, 1'($urandom), TW'($urandom));
   endtask

   task automatic drain(input int budget, input bit toggle);
      int n = 0;
      in_valid = 1'b0;
      while ((q.size() != 0 || out_valid === 1'b1) && n < budget) begin
         out_ready = toggle ? ~out_ready : 1'b1;
         tick();
         n++;
      end
      checks++;
      if (q.size() != 0 || out_valid === 1'b1) begin
         errors++;
         $display("FAIL drain: %0d results outstanding after %0d cycles, expected 0", q.size(), n);
      end
   endtask

   initial begin
      int acc0;
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, '0, '0, 1'b0, '0);
      d1_flush = 1'b0; d1_in_valid = 1'b0; d1_in_a = '0; d1_in_b = '0;
      d1_in_sub = 1'b0; d1_in_tag = '0; d1_out_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;

      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_sum", 64'(out_sum), 64'd0);
      check("rst_out_cout_ovf", 64'({out_cout, out_ovf}), 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_d1_valid_ready", 64'({d1_out_valid, d1_in_ready}), 64'b01);

      // Single-stage instance: registered adder, in_ready = out_ready | ~out_valid.
      tick();
      d1_in_valid = 1'b1; d1_in_a = 8'h7F; d1_in_b = 8'h01; d1_in_sub = 1'b0;
      d1_in_tag = 6'd5; d1_out_ready = 1'b1;
      tick();
      d1_in_valid = 1'b0; d1_out_ready = 1'b0;
      @(negedge clk);
      check("s1_valid", 64'(d1_out_valid), 64'd1);
      check("s1_sum", 64'(d1_out_sum), 64'h80);
      check("s1_cout_ovf", 64'({d1_out_cout, d1_out_ovf}), 64'b01);
      check("s1_tag", 64'(d1_out_tag), 64'd5);
      check("s1_in_ready_stalled", 64'(d1_in_ready), 64'd0);
      tick();
      @(negedge clk);
      check("s1_hold", 64'({d1_out_valid, d1_out_sum}), 64'h180);
      tick();
      d1_in_valid = 1'b1; d1_in_a = 8'h80; d1_in_b = 8'h01; d1_in_sub = 1'b1;
      d1_in_tag = 6'd6; d1_out_ready = 1'b1;
      @(negedge clk);
      check("s1_in_ready_drain", 64'(d1_in_ready), 64'd1);
      tick();
      d1_in_valid = 1'b0;
      @(negedge clk);
      check("s1_sub_sum", 64'({d1_out_valid, d1_out_sum}), 64'h17F);
      check("s1_sub_cout_ovf", 64'({d1_out_cout, d1_out_ovf, d1_out_tag}), 64'({1'b1, 1'b1, 6'd6}));
      tick();

      // Directed corners, back to back, latency checked.
      chk_lat = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, dir_a[i], dir_b[i], dir_s[i], dir_t[i]);
         tick();
      end
      drain(40, 1'b0);

      // Streaming: 8 random ops, full rate.
      for (int i = 0; i < 8; i++) begin
         drive_rand(1'b1);
         @(negedge clk);
         check("stream_in_ready", 64'(in_ready), 64'd1);
         tick();
      end
      drain(40, 1'b0);
      chk_lat = 1'b0;

      // Backpressure: capacity is exactly S ops.
      out_ready = 1'b0;
      acc0 = acc_cnt;
      for (int i = 0; i < 10; i++) begin
         drive_rand(1'b1);
         tick();
      end
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_accepted", 64'(acc_cnt - acc0), 64'(S));
      tick();
      drain(80, 1'b1);

      // Flush with 3 ops in flight; the op offered in the flush cycle is dropped.
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_rand(1'b1);
         tick();
      end
      drive_rand(1'b1);
      flush = 1'b1;
      @(negedge clk);
      check("flush_in_ready", 64'(in_ready), 64'd0);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      repeat (10) tick();
      check("flush_no_output", 64'(out_valid), 64'd0);

      // Random traffic with random backpressure.
      for (int i = 0; i < 300; i++) begin
         drive_rand(1'(($urandom % 4) != 0));
         out_ready = 1'(($urandom % 3) != 0);
         tick();
      end
      drain(80, 1'b0);

      // Reset with ops in flight.
      for (int i = 0; i < 3; i++) begin
         drive_rand(1'b1);
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst2_out_valid", 64'(out_valid), 64'd0);
      check("rst2_out_data", 64'({out_sum, out_cout, out_ovf, out_tag}), 64'd0);
      check("rst2_in_ready", 64'(in_ready), 64'd1);
      repeat (10) tick();
      check("rst2_no_output", 64'(out_valid), 64'd0);
      check("final_queue", 64'(q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
